tt_input_conditioner: RTL and testbench

Per-bit input conditioning stage sitting directly upstream of the user project core in the TinyTapeout harness. It takes raw `ui_in` pad levels (switches, push-buttons), synchronises them into `clk`, debounces each bit, and presents clean levels plus single-cycle rise/fall pulses that drive the core's `ui_in` port. A saturating glitch counter reports bounce activity for bring-up diagnostics.

---
 rtl/tt_input_conditioner.sv | 108 ++++++++++
 tb/tb_tt_input_conditioner.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tt_input_conditioner.sv
// Input conditioner for the TinyTapeout ui_in path: two-flop synchroniser,
// per-bit debounce with registered rise/fall pulses, saturating glitch counter.
module tt_input_conditioner #(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] raw_in,
    input  logic             clear_glitch,
    output logic [WIDTH-1:0] clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [7:0]       glitch_cnt
);
    localparam int            CW         = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE - 1);
    localparam logic [7:0]    GLITCH_MAX = 8'hFF;

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] clean_q;
    logic [WIDTH-1:0] clean_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [7:0]       glitch_q;
    logic [7:0]       glitch_d;
    logic             glitch_evt_s;

    // Per-bit debounce decision; a counter that falls back to zero without
    // accepting the new level marks an abandoned change.
    always_comb begin
        clean_d      = clean_q;
        rise_d       = '0;
        fall_d       = '0;
        cnt_d        = cnt_q;
        glitch_evt_s = 1'b0;
        if (ena) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s2_q[i] == clean_q[i]) begin
                    cnt_d[i] = '0;
                    if (cnt_q[i] != '0) begin
                        glitch_evt_s = 1'b1;
                    end else begin
                        glitch_evt_s = glitch_evt_s;
                    end
                end else if (cnt_q[i] == CNT_LAST) begin
                    clean_d[i] = s2_q[i];
                    cnt_d[i]   = '0;
                    rise_d[i]  = s2_q[i];
                    fall_d[i]  = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Glitch counter: one step per cycle with any event; clear wins.
    always_comb begin
        glitch_d = glitch_q;
        if (clear_glitch) begin
            glitch_d = 8'h00;
        end else if (glitch_evt_s && (glitch_q != GLITCH_MAX)) begin
            glitch_d = glitch_q + 8'h01;
        end else begin
            glitch_d = glitch_q;
        end
    end

    // State registers; the synchroniser keeps sampling while ena is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            clean_q  <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            glitch_q <= 8'h00;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= raw_in;
            s2_q     <= s1_q;
            clean_q  <= clean_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign clean      = clean_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_tt_input_conditioner.sv
// Self-checking bench for tt_input_conditioner (WIDTH=8, DEBOUNCE=4): each
// scenario queues per-cycle stimulus with expected outputs, then replays it.
module tb_tt_input_conditioner;
    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] raw_in;
    logic       clear_glitch;
    logic [7:0] clean;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] glitch_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [7:0] raw;
        logic       en;
        logic       clr;
        logic       rs;
        logic [7:0] clean;
        logic [7:0] rise;
        logic [7:0] fall;
        logic [7:0] glitch;
    } step_t;

    step_t sb[$];

    tt_input_conditioner #(.WIDTH(8), .DEBOUNCE(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .raw_in      (raw_in),
        .clear_glitch(clear_glitch),
        .clean       (clean),
        .rise        (rise),
        .fall        (fall),
        .glitch_cnt  (glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push(input logic [7:0] raw, input logic en, input logic clr,
                                 input logic rs, input logic [7:0] cl, input logic [7:0] ri,
                                 input logic [7:0] fa, input logic [7:0] gl);
        step_t s;
        s.raw = raw; s.en = en; s.clr = clr; s.rs = rs;
        s.clean = cl; s.rise = ri; s.fall = fa; s.glitch = gl;
        sb.push_back(s);
    endfunction

    task automatic do_reset();
        raw_in = 8'h00; ena = 1'b1; clear_glitch = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        step_t st;
        int    c = 0;
        raw_in = 8'hFF; ena = 1'b1; clear_glitch = 1'b0; rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({clean, rise, fall, glitch_cnt} !== 32'h0) begin
            $display("FAIL reset_async: got clean=%h rise=%h fall=%h glitch=%0d, expected all 0",
                     clean, rise, fall, glitch_cnt);
        end else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int t = 1; t <= 7; t++)
            push(8'hFF, 1'b1, 1'b0, 1'b0, (t >= 6) ? 8'hFF : 8'h00, (t == 6) ? 8'hFF : 8'h00,
                 8'h00, 8'h00);
        while (sb.size() > 0) begin
            st = sb.pop_front();
            raw_in = st.raw; ena = st.en; clear_glitch = st.clr; rst = st.rs;
            @(posedge clk); #1;
            c++;
            n_checks++;
            if ({clean, rise, fall, glitch_cnt} !== {st.clean, st.rise, st.fall, st.glitch})
                $display("FAIL reset_release cycle %0d: got clean=%h rise=%h fall=%h glitch=%0d, expected clean=%h rise=%h fall=%h glitch=%0d",
                         c, clean, rise, fall, glitch_cnt, st.clean, st.rise, st.fall, st.glitch);
            else n_pass++;
        end
    endtask

    task automatic test_clean_step();
        step_t st;
        int    c = 0;
        do_reset();
        for (int t = 1; t <= 7; t++)
            push(8'h01, 1'b1, 1'b0, 1'b0, (t >= 6) ? 8'h01 : 8'h00, (t == 6) ? 8'h01 : 8'h00,
                 8'h00, 8'h00);
        for (int t = 8; t <= 14; t++)
            push(8'h00, 1'b1, 1'b0, 1'b0, (t >= 13) ? 8'h00 : 8'h01, 8'h00,
                 (t == 13) ? 8'h01 : 8'h00, 8'h00);
        while (sb.size() > 0) begin
            st = sb.pop_front();
            raw_in = st.raw; ena = st.en; clear_glitch = st.clr; rst = st.rs;
            @(posedge clk); #1;
            c++;
            n_checks++;
            if ({clean, rise, fall, glitch_cnt} !== {st.clean, st.rise, st.fall, st.glitch})
                $display("FAIL clean_step cycle %0d: got clean=%h rise=%h fall=%h glitch=%0d, expected clean=%h rise=%h fall=%h glitch=%0d",
                         c, clean, rise, fall, glitch_cnt, st.clean, st.rise, st.fall, st.glitch);
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        step_t st;
        int    c = 0;
        do_reset();
        for (int t = 1; t <= 10; t++)
            push((t == 3) ? 8'h00 : 8'h08, 1'b1, 1'b0, 1'b0, (t >= 9) ? 8'h08 : 8'h00,
                 (t == 9) ? 8'h08 : 8'h00, 8'h00, (t >= 5) ? 8'd1 : 8'd0);
        while (sb.size() > 0) begin
            st = sb.pop_front();
            raw_in = st.raw; ena = st.en; clear_glitch = st.clr; rst = st.rs;
            @(posedge clk); #1;
            c++;
            n_checks++;
            if ({clean, rise, fall, glitch_cnt} !== {st.clean, st.rise, st.fall, st.glitch})
                $display("FAIL bounce cycle %0d: got clean=%h rise=%h fall=%h glitch=%0d, expected clean=%h rise=%h fall=%h glitch=%0d",
                         c, clean, rise, fall, glitch_cnt, st.clean, st.rise, st.fall, st.glitch);
            else n_pass++;
        end
    endtask

    task automatic test_glitch_saturate();
        step_t st;
        int    c = 0;
        int    g;
        do_reset();
        // Bits 1 and 5 bounce high for 2 cycles every 4; each bounce is one event.
        for (int t = 1; t <= 1201; t++) begin
            g = (t - 1) / 4;
            push((((t - 1) % 4) < 2 && t <= 1200) ? 8'h22 : 8'h00, 1'b1, 1'b0, 1'b0,
                 8'h00, 8'h00, 8'h00, (g > 255) ? 8'd255 : 8'(g));
        end
        for (int t = 1; t <= 11; t++)
            push((((t - 1) % 5) < 2 && t <= 10) ? 8'h22 : 8'h00, 1'b1,
                 (t == 5 || t == 10) ? 1'b1 : 1'b0, 1'b0, 8'h00, 8'h00, 8'h00,
                 (t < 5) ? 8'd255 : 8'd0);
        while (sb.size() > 0) begin
            st = sb.pop_front();
            raw_in = st.raw; ena = st.en; clear_glitch = st.clr; rst = st.rs;
            @(posedge clk); #1;
            c++;
            n_checks++;
            if ({clean, rise, fall, glitch_cnt} !== {st.clean, st.rise, st.fall, st.glitch})
                $display("FAIL glitch_saturate cycle %0d: got clean=%h rise=%h fall=%h glitch=%0d, expected clean=%h rise=%h fall=%h glitch=%0d",
                         c, clean, rise, fall, glitch_cnt, st.clean, st.rise, st.fall, st.glitch);
            else n_pass++;
        end
    endtask

    task automatic test_enable_freeze();
        step_t st;
        int    c = 0;
        do_reset();
        for (int t = 1; t <= 17; t++)
            push(8'h04, (t >= 5 && t <= 14) ? 1'b0 : 1'b1, 1'b0, 1'b0,
                 (t >= 16) ? 8'h04 : 8'h00, (t == 16) ? 8'h04 : 8'h00, 8'h00, 8'h00);
        while (sb.size() > 0) begin
            st = sb.pop_front();
            raw_in = st.raw; ena = st.en; clear_glitch = st.clr; rst = st.rs;
            @(posedge clk); #1;
            c++;
            n_checks++;
            if ({clean, rise, fall, glitch_cnt} !== {st.clean, st.rise, st.fall, st.glitch})
                $display("FAIL enable_freeze cycle %0d: got clean=%h rise=%h fall=%h glitch=%0d, expected clean=%h rise=%h fall=%h glitch=%0d",
                         c, clean, rise, fall, glitch_cnt, st.clean, st.rise, st.fall, st.glitch);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        step_t st;
        int    c = 0;
        do_reset();
        // Reset lands one edge before the expected rise[7]; a fresh count follows.
        for (int t = 1; t <= 12; t++)
            push(8'h80, 1'b1, 1'b0, (t == 6) ? 1'b1 : 1'b0, (t == 12) ? 8'h80 : 8'h00,
                 (t == 12) ? 8'h80 : 8'h00, 8'h00, 8'h00);
        while (sb.size() > 0) begin
            st = sb.pop_front();
            raw_in = st.raw; ena = st.en; clear_glitch = st.clr; rst = st.rs;
            @(posedge clk); #1;
            c++;
            n_checks++;
            if ({clean, rise, fall, glitch_cnt} !== {st.clean, st.rise, st.fall, st.glitch})
                $display("FAIL mid_reset cycle %0d: got clean=%h rise=%h fall=%h glitch=%0d, expected clean=%h rise=%h fall=%h glitch=%0d",
                         c, clean, rise, fall, glitch_cnt, st.clean, st.rise, st.fall, st.glitch);
            else n_pass++;
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({clean, rise, fall, glitch_cnt} !== 32'h0)
            $display("FAIL mid_pulse_reset: got clean=%h rise=%h fall=%h glitch=%0d, expected all 0",
                     clean, rise, fall, glitch_cnt);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_bounce();
        test_glitch_saturate();
        test_enable_freeze();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
